// File: rtl/xs3_conv_sched.sv
// Two-requester BCD-to-excess-3 converter: round-robin grant, then one digit
// per cycle (LSB first) through a shift register, result strobed in DONE.
module xs3_conv_sched #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [4*NDIG-1:0] din0,
  input  logic              req1,
  input  logic [4*NDIG-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic [4*NDIG-1:0] dout,
  output logic              dout_valid,
  output logic              dout_owner,
  output logic              err
);

  localparam int W = 4 * NDIG;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [3:0] f_xs3(input logic [3:0] dig);
    return dig + 4'd3;
  endfunction

  function automatic logic f_bcd_bad(input logic [3:0] dig);
    return (dig > 4'd9);
  endfunction

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [W-1:0] r_src;
  logic [W-1:0] r_res;
  logic [W-1:0] w_res_nxt;
  logic [3:0]   r_cnt;
  logic         r_err_acc;
  logic         r_owner;
  logic         r_last;
  logic [W-1:0] r_dout;
  logic         r_dout_valid;
  logic         r_dout_owner;
  logic         r_err;

  logic         w_pick1;
  logic         w_grant;
  logic [3:0]   w_dig;
  logic [3:0]   w_nib;
  logic         w_bad;
  logic         w_last;

  // Round-robin pick: with both requesting, serve the one not served last.
  always_comb begin
    w_pick1 = 1'b0;
    if (req0 && req1) begin
      w_pick1 = ~r_last;
    end else begin
      w_pick1 = req1;
    end
  end

  // rst_n gates the grant so nothing is granted while reset is held.
  assign w_grant = (r_state == ST_IDLE) && (req0 || req1) && rst_n;
  assign gnt0    = w_grant && !w_pick1;
  assign gnt1    = w_grant && w_pick1;

  assign w_dig  = r_src[3:0];
  assign w_nib  = f_xs3(w_dig);
  assign w_bad  = f_bcd_bad(w_dig);
  assign w_last = (r_cnt == 4'(NDIG - 1));

  // Place the converted nibble at the position of the digit being processed.
  always_comb begin
    w_res_nxt = r_res;
    w_res_nxt[{r_cnt, 2'b00} +: 4] = w_nib;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_CONV;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_CONV;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Conversion datapath: latch on grant, one digit per CONV cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src     <= {W{1'b0}};
      r_res     <= {W{1'b0}};
      r_cnt     <= 4'd0;
      r_err_acc <= 1'b0;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_src     <= w_pick1 ? din1 : din0;
            r_res     <= {W{1'b0}};
            r_cnt     <= 4'd0;
            r_err_acc <= 1'b0;
            r_owner   <= w_pick1;
            r_last    <= w_pick1;
          end
        end
        ST_CONV: begin
          r_src     <= r_src >> 3'd4;
          r_res     <= w_res_nxt;
          r_cnt     <= r_cnt + 4'd1;
          r_err_acc <= r_err_acc | w_bad;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Result registers: loaded on the last digit so they are valid in DONE and hold after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= {W{1'b0}};
      r_dout_valid <= 1'b0;
      r_dout_owner <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if ((r_state == ST_CONV) && w_last) begin
        r_dout       <= w_res_nxt;
        r_dout_valid <= 1'b1;
        r_dout_owner <= r_owner;
        r_err        <= r_err_acc | w_bad;
      end else begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign dout_owner = r_dout_owner;
  assign err        = r_err;

endmodule

// File: doc/xs3_conv_sched.md
XS3_CONV_SCHED -- requirements
Module: xs3_conv_sched

Interface
REQ-001 The block SHALL have parameter NDIG, default 4, setting the number of BCD digits per word (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port req0, input, 1 bit, requester 0 conversion request, held high until granted.
REQ-005 The block SHALL have port din0, input, 4*NDIG bits, requester 0 packed BCD word, digit 0 in bits [3:0].
REQ-006 The block SHALL have port req1, input, 1 bit, requester 1 conversion request, held high until granted.
REQ-007 The block SHALL have port din1, input, 4*NDIG bits, requester 1 packed BCD word.
REQ-008 The block SHALL have ports gnt0 and gnt1, outputs, 1 bit each, single-cycle grant pulses to the matching requester.
REQ-009 The block SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-010 The block SHALL have port dout, output, 4*NDIG bits, packed excess-3 result.
REQ-011 The block SHALL have port dout_valid, output, 1 bit, single-cycle result strobe.
REQ-012 The block SHALL have port dout_owner, output, 1 bit, index of the requester owning dout.
REQ-013 The block SHALL have port err, output, 1 bit, high with dout_valid when any digit of the word exceeded 9.

Function
REQ-014 The block SHALL implement states IDLE, CONV, DONE.
REQ-015 In IDLE with any req high, the block SHALL pulse exactly one gnt, latch the granted din into a shift register, clear the digit counter and the error flag, and enter CONV on the next edge.
REQ-016 Arbitration SHALL be round-robin: a last-served pointer (reset to 1) selects the requester not last served when both requests are high; a single request is granted regardless of the pointer; the pointer updates on each grant.
REQ-017 In CONV the block SHALL convert one digit per cycle, LSB digit first; each result nibble = digit + 3 modulo 16, shifted into the result register.
REQ-018 A digit value 10..15 SHALL set the error flag, and the nibble SHALL still be digit + 3 modulo 16.
REQ-019 After NDIG CONV cycles the block SHALL enter DONE; in DONE dout_valid = 1, dout = complete result, dout_owner = granted index, err = error flag; next state is IDLE.
REQ-020 Latency: grant in cycle T, dout_valid in cycle T+NDIG+1; minimum spacing between grants is NDIG+2 cycles.
REQ-021 busy SHALL be high in CONV and DONE and low in IDLE.
REQ-022 Requests arriving in CONV or DONE SHALL NOT be granted; they SHALL be arbitrated on the first IDLE cycle.
REQ-023 dout, dout_owner and err SHALL hold their last values outside DONE; dout_valid SHALL be low outside DONE.
REQ-024 Changes on din0 or din1 after the grant SHALL NOT affect the conversion in progress.
REQ-025 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-026 While rst_n is low, the block SHALL hold state IDLE, gnt0 = gnt1 = 0, busy = 0, dout = 0, dout_valid = 0, dout_owner = 0, err = 0, digit counter = 0, last-served pointer = 1.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion immediately with no dout_valid, and the aborted requester SHALL NOT be re-granted unless its req is still high.
REQ-028 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge at which rst_n is high.

Verification
REQ-029 NDIG=4, req0=1, din0=16'h1234 -> gnt0 pulse at T; dout=16'h4567, dout_owner=0, err=0, dout_valid at T+5.
REQ-030 req0 and req1 both high after reset, din0=16'h0000, din1=16'h9999 -> gnt0 first, dout=16'h3333; then gnt1 at T+6, dout=16'hCCCC, owner=1.
REQ-031 din1=16'h00A5, req1 only -> dout=16'h33D8, err=1, owner=1.
REQ-032 rst_n low two cycles after gnt0 -> busy=0 and dout_valid=0 immediately; no dout_valid follows unless a new grant occurs.
REQ-033 Both req held high continuously -> grants alternate 0,1,0,1 every 6 cycles; gnt0 and gnt1 never overlap.
REQ-034 din0 changed from 16'h0001 to 16'h9999 one cycle after gnt0 -> dout=16'h3334.
